// File: rtl/ro_puf_eval.sv
// ro_puf_eval - ring-oscillator PUF evaluator.
//
// Enables one pair of oscillators at a time from an external bank of NUM_RO
// ring oscillators. For each of RESP_BITS pairs it counts synchronised rising
// edges over a WINDOW-cycle window and compares the two counts. The result is
// returned as a RESP_BITS-wide response.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, ACTIVE-HIGH (1 = reset)
//   start      evaluation request, sampled only while idle
//   challenge  {sel_a, sel_b} base pair indices, captured on accepted start
//   osc_in     raw oscillator outputs (asynchronous to clk)
//   ro_en      oscillator enables (the selected pair only)
//   busy       evaluation in progress
//   done       one-cycle completion pulse; response/err valid from here on
//   response   bit k = (count_a > count_b) for pair k
//   cnt_a/b    final counts of the most recent pair
//   err        degenerate challenge (sel_a == sel_b) or counter saturation
//
// Build option: define RO_PUF_MAJORITY_EN to run every pair three times and
// report the majority vote; cnt_a/cnt_b then report the third run.
module ro_puf_eval #(
    parameter int NUM_RO    = 16,
    parameter int SEL_W     = $clog2(NUM_RO),
    parameter int CNT_W     = 12,
    parameter int WINDOW    = 1024,
    parameter int SETTLE    = 16,
    parameter int RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*SEL_W-1:0]   challenge,
    input  logic [NUM_RO-1:0]    osc_in,
    output logic [NUM_RO-1:0]    ro_en,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic [CNT_W-1:0]     cnt_a,
    output logic [CNT_W-1:0]     cnt_b,
    output logic                 err
);

    localparam int TMAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TW   = $clog2(TMAX);
    localparam int KW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    // S_WRAP is the one busy cycle between the final compare (or a rejected
    // challenge) and the done pulse.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_COMPARE,
        S_WRAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tmr_q;
    logic [KW-1:0]      k_q;
    logic [SEL_W-1:0]   off_q;
    logic [SEL_W-1:0]   sel_a_q, sel_b_q;
    logic [SEL_W-1:0]   sel_a, sel_b;
    logic [SEL_W-1:0]   idx_a, idx_b;
    logic [CNT_W-1:0]   ca_q, cb_q;
    logic [2:0]         sync_a_q, sync_b_q;
    logic               rise_a, rise_b;
    logic               tmr_last, last_pair, last_run, a_gt_b;

`ifdef RO_PUF_MAJORITY_EN
    logic [1:0]         run_q;
    logic [1:0]         votes_q;
    logic               vote_maj;
`endif

    assign sel_a = challenge[2*SEL_W-1:SEL_W];
    assign sel_b = challenge[SEL_W-1:0];

    // Pair index wraps naturally modulo NUM_RO (a power of two).
    assign idx_a = sel_a_q + off_q;
    assign idx_b = sel_b_q + off_q;

    // sync_x_q[1:0] is the 2-FF synchroniser, sync_x_q[2] the edge register.
    assign rise_a = sync_a_q[1] & ~sync_a_q[2];
    assign rise_b = sync_b_q[1] & ~sync_b_q[2];

    assign tmr_last  = ((state_q == S_SETTLE) && (tmr_q == TW'(SETTLE - 1))) ||
                       ((state_q == S_COUNT)  && (tmr_q == TW'(WINDOW - 1)));
    assign last_pair = (k_q == KW'(RESP_BITS - 1));
    assign a_gt_b    = (ca_q > cb_q);

`ifdef RO_PUF_MAJORITY_EN
    assign last_run = (run_q == 2'd2);
    assign vote_maj = (votes_q[0] & votes_q[1]) | (votes_q[0] & a_gt_b) |
                      (votes_q[1] & a_gt_b);
`else
    assign last_run = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        ro_en   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (sel_a != sel_b) ? S_SETTLE : S_WRAP;
            end
            S_SETTLE: begin
                busy         = 1'b1;
                ro_en[idx_a] = 1'b1;
                ro_en[idx_b] = 1'b1;
                if (tmr_last) state_d = S_COUNT;
            end
            S_COUNT: begin
                busy         = 1'b1;
                ro_en[idx_a] = 1'b1;
                ro_en[idx_b] = 1'b1;
                if (tmr_last) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                busy    = 1'b1;
                state_d = (last_run && last_pair) ? S_WRAP : S_SETTLE;
            end
            S_WRAP: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tmr_q    <= '0;
            k_q      <= '0;
            off_q    <= '0;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            ca_q     <= '0;
            cb_q     <= '0;
            sync_a_q <= '0;
            sync_b_q <= '0;
            response <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            err      <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
            run_q    <= '0;
            votes_q  <= '0;
`endif
        end else begin
            sync_a_q <= {sync_a_q[1:0], osc_in[idx_a]};
            sync_b_q <= {sync_b_q[1:0], osc_in[idx_b]};
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_a_q  <= sel_a;
                        sel_b_q  <= sel_b;
                        response <= '0;
                        err      <= (sel_a == sel_b);
                        k_q      <= '0;
                        off_q    <= '0;
                        tmr_q    <= '0;
`ifdef RO_PUF_MAJORITY_EN
                        run_q    <= '0;
                        votes_q  <= '0;
`endif
                    end
                end
                S_SETTLE: begin
                    ca_q  <= '0;
                    cb_q  <= '0;
                    tmr_q <= tmr_last ? '0 : tmr_q + TW'(1);
                end
                S_COUNT: begin
                    tmr_q <= tmr_last ? '0 : tmr_q + TW'(1);
                    if (rise_a) begin
                        if (&ca_q) err  <= 1'b1;
                        else       ca_q <= ca_q + CNT_W'(1);
                    end
                    if (rise_b) begin
                        if (&cb_q) err  <= 1'b1;
                        else       cb_q <= cb_q + CNT_W'(1);
                    end
                end
                S_COMPARE: begin
                    cnt_a <= ca_q;
                    cnt_b <= cb_q;
`ifdef RO_PUF_MAJORITY_EN
                    if (!last_run) begin
                        votes_q[run_q[0]] <= a_gt_b;
                        run_q             <= run_q + 2'd1;
                    end else begin
                        response[k_q] <= vote_maj;
                        run_q         <= '0;
                        k_q           <= k_q + KW'(1);
                        off_q         <= off_q + SEL_W'(1);
                    end
`else
                    response[k_q] <= a_gt_b;
                    k_q           <= k_q + KW'(1);
                    off_q         <= off_q + SEL_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ro_puf_eval.md
# ro_puf_eval

Parametrised ring-oscillator PUF evaluator, the successor of the fixed 8-oscillator mux/counter/compare path. It drives the enables of an external bank of `NUM_RO` ring oscillators and evaluates a sequence of `RESP_BITS` oscillator pairs. For each pair it counts synchronised rising edges over a fixed clock window and compares the two counts. The result is a multi-bit response delivered with a start/busy/done handshake. It sits between the oscillator bank and the top-level pin mapping.

## Interface
- `NUM_RO`, 16: number of oscillators; power of two, at least 4.
- `SEL_W`, $clog2(NUM_RO): derived; not overridden.
- `CNT_W`, 12: edge-counter width.
- `WINDOW`, 1024: count window length in `clk` cycles; at least 2, and less than 2^CNT_W·2.
- `SETTLE`, 16: cycles the pair runs before counting starts (oscillator start-up plus synchroniser flush); at least 3.
- `RESP_BITS`, 8: number of response bits per evaluation.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-high (1 = reset).
- `start`  in  1  evaluation request; sampled only in IDLE.
- `challenge`  in  2·SEL_W  {sel_a, sel_b}, the base pair indices; captured on accepted start.
- `osc_in`  in  NUM_RO  raw oscillator outputs, asynchronous to `clk`.
- `ro_en`  out  NUM_RO  oscillator enables.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse; `response` and `err` are valid from this cycle.
- `response`  out  RESP_BITS  bit k is the result for pair k.
- `cnt_a`, `cnt_b`  out  CNT_W each  final counts of the most recent pair.
- `err`  out  1  set on a degenerate challenge or counter saturation.

## Operation
- **Pair k selection:** a_k = (sel_a + k) mod NUM_RO and b_k = (sel_b + k) mod NUM_RO, for k = 0 … RESP_BITS−1.
- **IDLE:**
  - `start`=1 with sel_a ≠ sel_b: capture the challenge, clear `response` and `err`, set k = 0, go to SETTLE.
  - `start`=1 with sel_a == sel_b: go to DONE with `err`=1 and `response`=0; no oscillator is enabled.
- **SETTLE:**
  - `ro_en` is one-hot-pair: bits a_k and b_k set, all others 0.
  - Both counters are cleared.
  - Lasts exactly `SETTLE` cycles, then go to COUNT.
- **COUNT:**
  - The selected `osc_in` bits each pass through a 2-FF synchroniser plus an edge register.
  - Each synchronised rising edge increments its counter.
  - Counters saturate at all-ones; saturation sets `err` (sticky for this evaluation).
  - Lasts exactly `WINDOW` cycles.
- **COMPARE** (1 cycle):
  - `ro_en` = 0.
  - response[k] = (cnt_a > cnt_b); a tie gives 0.
  - `cnt_a` and `cnt_b` outputs update.
  - If k < RESP_BITS−1: k++, go to SETTLE. Otherwise go to DONE.
- **DONE** (1 cycle): `done`=1, `busy`=0, then IDLE.
- **Output holding:** `response`, `cnt_a`, `cnt_b` and `err` hold until the next accepted start.
- **Other start cases:**
  - `start` while busy is ignored.
  - `start` held high re-triggers in the cycle after DONE.
- **Frequency limit:** counting is exact only for oscillator frequencies below f_clk/2. Faster signals alias, and the external bank divides them beforehand.

## Timing
- **Reset values:** `ro_en`=0, `busy`=0, `done`=0, `response`=0, `cnt_a`=0, `cnt_b`=0, `err`=0, state IDLE.
- **Reset mid-evaluation:** takes effect on the next edge. All of the above are restored, no `done` pulse is issued, and the partial response is discarded.
- **Latency:**
  - An accepted `start` sampled at edge 0 gives `busy`=1 after edge 0.
  - `done`=1 after edge RESP_BITS·(SETTLE+WINDOW+1)+1.
  - A degenerate challenge gives `done` after edge 1.
- **Enable window:** `ro_en` is asserted for SETTLE+WINDOW cycles per pair. It is deasserted for exactly 1 cycle (COMPARE) between pairs.
- **Edge capture:** an edge arriving in the last 2 cycles of COUNT may miss the window because of synchroniser delay. This is accepted and is symmetric for both channels.

## Configuration
- `RO_PUF_MAJORITY_EN` defined:
  - Each pair runs SETTLE→COUNT→COMPARE three times.
  - response[k] is the majority of the three comparisons.
  - `cnt_a` and `cnt_b` report the third run.
  - Latency becomes 3·RESP_BITS·(SETTLE+WINDOW+1)+1.
- Undefined: a single run per pair, as described above.

## Test plan
All scenarios use NUM_RO=8, RESP_BITS=4, WINDOW=64, SETTLE=4, macro undefined unless stated.

1. Reset: pulse `rst_n`=1 for 1 cycle -> all outputs 0, state IDLE, `start` accepted next cycle.
2. Fixed pair ordering: osc 0 has period 8 clk and osc 1 has period 12 clk; challenge {0,1} -> the pair-0 counts are 8±1 (`cnt_a`) and 5±1 (`cnt_b`), so response[0]=1. Pairs (1,2), (2,3) and (3,4) then follow their programmed periods. `done` after cycle 277.
3. Wrap-around: challenge {6,7} -> pairs (6,7), (7,0), (0,1) and (1,2), with `ro_en` observed as 0xC0, 0x81, 0x03 and 0x06.
4. Degenerate challenge: challenge {3,3} -> `done` after cycle 1, `err`=1, `response`=0, `ro_en` never nonzero.
5. Control: `start` pulsed while busy is ignored, with `done` appearing exactly once. `rst_n` asserted during pair 2 -> `ro_en`=0 and `busy`=0 next cycle, and no `done` pulse.
6. Saturation: CNT_W=4 and osc at period 2 clk (aliasing) -> `err`=1 and counts pinned at 15. Separately, with `RO_PUF_MAJORITY_EN` and a bench-scripted tie-break pattern of 1,0,1 -> response bit 1 and latency 829 cycles.
